// File: rtl/complex_pkg.sv
// rtl/complex_pkg.sv - complex sample type and accumulator burst constants
package complex_pkg;

   typedef struct packed {
      logic [31:0] r;
      logic [31:0] i;
   } complex_t;

   localparam int ACC_MIN_LEN = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FILL,
      ST_NEXT,
      ST_RUN,
      ST_DONE
   } feeder_state_t;

endpackage

// File: rtl/complex_sync_fifo.sv
// rtl/complex_sync_fifo.sv - single-clock complex_t FIFO with registered read data
module complex_sync_fifo
   import complex_pkg::*;
#(
   parameter int DEPTH_BITS = 9
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                push,
   input  logic                pop,
   input  complex_t            din,
   output complex_t            dout,
   output logic [DEPTH_BITS:0] count,
   output logic                full,
   output logic                empty
);

   localparam int DEPTH = 1 << DEPTH_BITS;

   complex_t                mem [DEPTH];
   logic [DEPTH_BITS-1:0]   wr_ptr_q, wr_ptr_d;
   logic [DEPTH_BITS-1:0]   rd_ptr_q, rd_ptr_d;
   logic [DEPTH_BITS:0]     count_q, count_d;
   complex_t                dout_q, dout_d;
   logic                    do_push, do_pop;

   assign full    = (count_q == (DEPTH_BITS+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = dout_q;
   assign count   = count_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      dout_d   = dout_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
         dout_d   = mem[rd_ptr_q];
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         dout_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         dout_q   <= dout_d;
      end
   end

   // Storage is not reset; clearing the pointers is what discards buffered data.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_q] <= din;
      end
   end

endmodule

// File: rtl/accumulator_feeder.sv
// rtl/accumulator_feeder.sv - buffers complex samples and emits next-framed bursts
module accumulator_feeder
   import complex_pkg::*;
#(
   parameter int MAX_SIZE_BITS   = 9,
   parameter int FIFO_DEPTH_BITS = 9
) (
   input  logic                     clk,
   input  logic                     reset,
   input  complex_t                 in,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     config_valid,
   input  logic [MAX_SIZE_BITS-1:0] config_length,
   output logic                     config_ready,
   output logic                     cfg_error,
   output complex_t                 out,
   output logic                     next,
   output logic                     busy,
   output logic                     done
);

   feeder_state_t              state_q, state_d;
   logic [MAX_SIZE_BITS-1:0]   len_q, len_d;
   logic [MAX_SIZE_BITS-1:0]   run_cnt_q, run_cnt_d;
   logic                       cfg_err_q, cfg_err_d;

   logic                       fifo_pop;
   logic                       fifo_full;
   logic                       fifo_empty;
   logic [FIFO_DEPTH_BITS:0]   fifo_count;
   complex_t                   fifo_dout;

   complex_sync_fifo #(
      .DEPTH_BITS(FIFO_DEPTH_BITS)
   ) u_fifo (
      .clk   (clk),
      .rst_n (reset),
      .push  (in_valid),
      .pop   (fifo_pop),
      .din   (in),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      run_cnt_d = run_cnt_q;
      cfg_err_d = 1'b0;
      fifo_pop  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (config_valid) begin
               if (config_length >= MAX_SIZE_BITS'(ACC_MIN_LEN)) begin
                  len_d   = config_length;
                  state_d = ST_FILL;
               end else begin
                  cfg_err_d = 1'b1;
               end
            end
         end
         ST_FILL: begin
            if (fifo_count >= (FIFO_DEPTH_BITS+1)'(len_q)) begin
               state_d = ST_NEXT;
            end
         end
         ST_NEXT: begin
            fifo_pop  = 1'b1;
            run_cnt_d = len_q - 1'b1;
            state_d   = ST_RUN;
         end
         ST_RUN: begin
            // The pop for the final sample already happened, so the last RUN cycle only drains dout.
            if (run_cnt_q == '0) begin
               state_d = ST_DONE;
            end else begin
               fifo_pop  = 1'b1;
               run_cnt_d = run_cnt_q - 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         len_q     <= '0;
         run_cnt_q <= '0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         run_cnt_q <= run_cnt_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   assign in_ready     = !fifo_full;
   assign config_ready = (state_q == ST_IDLE);
   assign cfg_error    = cfg_err_q;
   assign next         = (state_q == ST_NEXT);
   assign busy         = (state_q != ST_IDLE);
   assign done         = (state_q == ST_DONE);
   assign out          = (state_q == ST_RUN) ? fifo_dout : '0;

endmodule

// File: tb/tb_accumulator_feeder.sv
// tb/tb_accumulator_feeder.sv - scoreboard bench for accumulator_feeder
module tb_accumulator_feeder;
   import complex_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   complex_t   drv_in = '0;
   logic       drv_valid = 1'b0;
   logic       in_ready;
   logic       cfg_valid = 1'b0;
   logic [8:0] cfg_len = '0;
   logic       config_ready;
   logic       cfg_error;
   complex_t   out_s;
   logic       next_s;
   logic       busy;
   logic       done_s;

   int errors = 0;
   int checks = 0;
   int seq = 0;

   complex_t exp_q[$];
   int       burst_q[$];

   always #5 clk = ~clk;

   accumulator_feeder #(
      .MAX_SIZE_BITS(9),
      .FIFO_DEPTH_BITS(9)
   ) dut (
      .clk           (clk),
      .reset         (rst_n),
      .in            (drv_in),
      .in_valid      (drv_valid),
      .in_ready      (in_ready),
      .config_valid  (cfg_valid),
      .config_length (cfg_len),
      .config_ready  (config_ready),
      .cfg_error     (cfg_error),
      .out           (out_s),
      .next          (next_s),
      .busy          (busy),
      .done          (done_s)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic complex_t mk(input int k);
      logic [31:0] w;
      w = 32'h4348_0000 + 32'(k * 16);
      return '{r: w, i: w};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_one();
      drv_in    = mk(seq);
      drv_valid = 1'b1;
      exp_q.push_back(mk(seq));
      seq++;
      tick();
      drv_valid = 1'b0;
   endtask

   task automatic send_cfg(input int len, input bit expect_burst);
      chk("config_ready_before_cfg", config_ready, 1'b1);
      cfg_valid = 1'b1;
      cfg_len   = 9'(len);
      if (expect_burst) burst_q.push_back(len);
      tick();
      cfg_valid = 1'b0;
   endtask

   task automatic wait_done(input int limit);
      int n;
      n = 0;
      while (done_s !== 1'b1 && n < limit) begin
         tick();
         n++;
      end
      chk("done_within_budget", (n < limit), 1'b1);
   endtask

   // Monitor: next opens a burst whose length was queued by the stimulus; each
   // following cycle must carry the next expected sample, then done for one cycle.
   int  remaining = 0;
   bit  in_burst = 0;
   bit  done_exp = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         in_burst  = 0;
         remaining = 0;
         done_exp  = 0;
         exp_q.delete();
         burst_q.delete();
      end else begin
         chk("done_pulse", done_s, done_exp);
         done_exp = 0;
         if (in_burst) begin
            chk("next_in_burst", next_s, 1'b0);
            if (exp_q.size() == 0) begin
               chk("burst_sample_available", 1'b0, 1'b1);
            end else begin
               chk("burst_out", out_s, exp_q.pop_front());
            end
            remaining--;
            if (remaining == 0) begin
               in_burst = 0;
               done_exp = 1;
            end
         end else begin
            chk("idle_out_zero", out_s, 64'h0);
            if (next_s) begin
               if (burst_q.size() == 0) begin
                  chk("unexpected_next", next_s, 1'b0);
               end else begin
                  remaining = burst_q.pop_front();
                  in_burst  = 1;
               end
            end
         end
      end
   end

   initial begin
      int n;
      #12;
      chk("rst_next", next_s, 1'b0);
      chk("rst_done", done_s, 1'b0);
      chk("rst_cfg_error", cfg_error, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_out", out_s, 64'h0);
      chk("rst_config_ready", config_ready, 1'b1);
      chk("rst_in_ready", in_ready, 1'b1);
      tick();
      rst_n = 1'b1;
      tick();

      // Buffered samples first, then a burst of 5
      for (int k = 0; k < 5; k++) push_one();
      send_cfg(5, 1'b1);
      wait_done(20);
      tick(); tick();
      chk("count_after_l5", dut.u_fifo.count, 10'd0);

      // Config first, samples trickle in every 3 cycles
      send_cfg(4, 1'b0);
      chk("busy_while_fill", busy, 1'b1);
      for (int k = 0; k < 4; k++) begin
         push_one();
         if (k < 3) begin
            tick(); tick();
            chk("no_next_while_fill", next_s, 1'b0);
         end
      end
      burst_q.push_back(4);
      wait_done(20);
      tick();

      // Rejected length
      send_cfg(2, 1'b0);
      chk("cfg_error_pulse", cfg_error, 1'b1);
      chk("config_ready_after_reject", config_ready, 1'b1);
      chk("busy_after_reject", busy, 1'b0);
      tick();
      chk("cfg_error_cleared", cfg_error, 1'b0);
      tick(); tick();

      // Fill to full, one dropped push, then a 511 burst
      for (int k = 0; k < 512; k++) push_one();
      chk("in_ready_full", in_ready, 1'b0);
      drv_in    = mk(9999);
      drv_valid = 1'b1;
      tick();
      drv_valid = 1'b0;
      chk("count_full_after_drop", dut.u_fifo.count, 10'd512);
      send_cfg(511, 1'b1);
      wait_done(600);
      tick(); tick();
      chk("count_leftover", dut.u_fifo.count, 10'd1);

      // Two back-to-back L=8 bursts while pushing every cycle
      for (int k = 0; k < 7; k++) push_one();
      for (int i = 0; i < 26; i++) begin
         drv_in    = mk(seq);
         drv_valid = 1'b1;
         exp_q.push_back(mk(seq));
         seq++;
         if (i == 0 || i == 12) begin
            chk("config_ready_run_test", config_ready, 1'b1);
            cfg_valid = 1'b1;
            cfg_len   = 9'd8;
            burst_q.push_back(8);
         end
         tick();
         cfg_valid = 1'b0;
      end
      drv_valid = 1'b0;
      tick(); tick();
      chk("count_after_run_push", dut.u_fifo.count, 10'(exp_q.size()));
      chk("count_after_run_push_abs", dut.u_fifo.count, 10'd18);

      // Asynchronous reset in the third RUN cycle
      send_cfg(4, 1'b1);
      n = 0;
      while (next_s !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      chk("next_seen_before_reset", next_s, 1'b1);
      tick(); tick(); tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_out", out_s, 64'h0);
      chk("async_rst_busy", busy, 1'b0);
      chk("async_rst_next", next_s, 1'b0);
      chk("async_rst_done", done_s, 1'b0);
      chk("async_rst_cfg_error", cfg_error, 1'b0);
      chk("async_rst_config_ready", config_ready, 1'b1);
      chk("async_rst_in_ready", in_ready, 1'b1);
      chk("async_rst_count", dut.u_fifo.count, 10'd0);
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) tick();
      chk("config_ready_after_release", config_ready, 1'b1);
      chk("count_after_release", dut.u_fifo.count, 10'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
